// File: rtl/uart_tx.sv
// UART transmitter: start bit, DataBits data bits LSB first, then a stop period of SbTicks
// ticks. Bit timing comes from a 16x oversample tick that is supplied from outside.
module uart_tx #(
    parameter int DataBits = 8,
    parameter int SbTicks  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                s_tick_i,
    input  logic                tx_start_i,
    input  logic [DataBits-1:0] din_i,
    output logic                tx_o,
    output logic                busy_o,
    output logic                tx_done_tick_o
);
    localparam int SW = (SbTicks > 16) ? 5 : 4;
    localparam int NW = (DataBits > 1) ? $clog2(DataBits) : 1;
    localparam logic [SW-1:0] SLast = SW'(15);
    localparam logic [SW-1:0] SStop = SW'(SbTicks - 1);
    localparam logic [SW-1:0] SOne  = SW'(1);
    localparam logic [NW-1:0] NLast = NW'(DataBits - 1);
    localparam logic [NW-1:0] NOne  = NW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_nxt;
    logic [SW-1:0]       s, s_nxt;
    logic [NW-1:0]       n, n_nxt;
    logic [DataBits-1:0] b, b_nxt;
    logic                tx_q, tx_nxt;
    logic                done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            n     <= n_nxt;
            b     <= b_nxt;
            tx_q  <= tx_nxt;
        end
    end

    // tx_nxt anticipates the line level of the next state, so tx_o stays a plain flop output.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        n_nxt     = n;
        b_nxt     = b;
        tx_nxt    = tx_q;
        done      = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (tx_start_i) begin
                    state_nxt = START;
                    b_nxt     = din_i;
                    s_nxt     = '0;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (s_tick_i) begin
                    if (s == SLast) begin
                        state_nxt = DATA;
                        s_nxt     = '0;
                        n_nxt     = '0;
                        tx_nxt    = b[0];
                    end else begin
                        s_nxt = s + SOne;
                    end
                end
            end
            DATA: begin
                if (s_tick_i) begin
                    if (s == SLast) begin
                        s_nxt = '0;
                        b_nxt = b >> 1;
                        if (n == NLast) begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end else begin
                            n_nxt  = n + NOne;
                            tx_nxt = b[1];
                        end
                    end else begin
                        s_nxt = s + SOne;
                    end
                end
            end
            STOP: begin
                if (s_tick_i) begin
                    if (s == SStop) begin
                        state_nxt = IDLE;
                        done      = 1'b1;
                    end else begin
                        s_nxt = s + SOne;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_o           = tx_q;
    assign busy_o         = (state != IDLE);
    assign tx_done_tick_o = done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a line monitor decodes frames from the default instance,
// and cycle-exact checks cover the basic frame and a 7-bit / 2-stop-bit instance.
module tb_uart_tx;
    localparam int D7  = 7;
    localparam int SB7 = 32;
    localparam int FL7 = 16 * (1 + D7) + SB7;

    typedef struct {
        logic [7:0] data;
        bit         err;
        int         cyc;
    } frame_t;

    logic          clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic          start = 1'b0, start7 = 1'b0;
    logic [7:0]    din = '0;
    logic [D7-1:0] din7 = '0;
    logic          tx, busy, done, tx7, busy7, done7;

    int vectors = 0, miscompares = 0;
    int tick_mode = 0;
    int mcnt = 0, gap = 0;

    logic [7:0] exp_q[$];
    frame_t     rx_q[$];

    always #5 clk = ~clk;

    uart_tx dut (
        .clk_i(clk), .rst_ni(rst_n), .s_tick_i(tick), .tx_start_i(start), .din_i(din),
        .tx_o(tx), .busy_o(busy), .tx_done_tick_o(done)
    );

    uart_tx #(.DataBits(D7), .SbTicks(SB7)) dut7 (
        .clk_i(clk), .rst_ni(rst_n), .s_tick_i(tick), .tx_start_i(start7), .din_i(din7),
        .tx_o(tx7), .busy_o(busy7), .tx_done_tick_o(done7)
    );

    // 0: tick every cycle, 1: mod-53 counter, 2: random gaps of 0-5 cycles
    always @(posedge clk) begin
        #1;
        case (tick_mode)
            0: tick = 1'b1;
            1: begin
                mcnt = (mcnt == 52) ? 0 : mcnt + 1;
                tick = (mcnt == 52);
            end
            default: begin
                if (gap == 0) begin
                    tick = 1'b1;
                    gap  = $urandom_range(0, 5);
                end else begin
                    tick = 1'b0;
                    gap--;
                end
            end
        endcase
    end

    // Line monitor: counts ticks from the start bit, samples mid-bit, checks bit edges on 16-tick bounds.
    bit         mon_on = 0, mon_err = 0;
    int         tcnt = 0, fcyc = 0, stray_done = 0, chg_err = 0;
    logic [7:0] mon_bits = '0;
    logic       mon_prev = 1'b0;
    logic       prev_tx = 1'b1, prev_tick = 1'b0, prev_busy = 1'b0, prev_rst = 1'b0;

    always @(negedge clk) begin
        if (rst_n && prev_rst && prev_busy && !prev_tick && tx !== prev_tx) chg_err++;
        prev_tx = tx; prev_tick = tick; prev_busy = busy; prev_rst = rst_n;
        if (!rst_n) begin
            mon_on = 0;
        end else begin
            if (!mon_on && done) stray_done++;
            if (!mon_on && busy && !tx) begin
                mon_on = 1; tcnt = 0; fcyc = 0; mon_bits = '0; mon_err = 0; mon_prev = 1'b0;
            end
            if (mon_on) begin
                fcyc++;
                if (tx !== mon_prev && (tcnt % 16) != 0) mon_err = 1;
                mon_prev = tx;
                if (done) begin
                    if (tcnt != 159 || !tick) mon_err = 1;
                    rx_q.push_back('{mon_bits, mon_err, fcyc});
                    mon_on = 0;
                end else if (tick) begin
                    if (tcnt == 8 && tx !== 1'b0) mon_err = 1;
                    if (tcnt == 152 && tx !== 1'b1) mon_err = 1;
                    for (int j = 0; j < 8; j++) if (tcnt == 16 * (j + 1) + 8) mon_bits[j] = tx;
                    tcnt++;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start7 = 1'b0; tick_mode = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({tx, busy, done} !== 3'b100) begin
            miscompares++; $display("FAIL reset_dut tx/busy/done got %b want 100", {tx, busy, done});
        end
        vectors++;
        if ({tx7, busy7, done7} !== 3'b100) begin
            miscompares++; $display("FAIL reset_dut7 tx/busy/done got %b want 100", {tx7, busy7, done7});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({tx, busy, done} !== 3'b100) begin
            miscompares++; $display("FAIL idle_after_reset got %b want 100", {tx, busy, done});
        end
    endtask

    task automatic test_basic();
        logic [7:0] v = 8'hA5;
        logic [2:0] e;
        frame_t     r;
        tick_mode = 0;
        repeat (2) @(posedge clk);
        #1 din = v; start = 1'b1; exp_q.push_back(v);
        @(posedge clk); #1 start = 1'b0; din = 8'h00;
        for (int c = 1; c <= 161; c++) begin
            @(negedge clk);
            if (c <= 16) e = 3'b010;
            else if (c <= 144) e = {v[(c - 17) / 16], 2'b10};
            else if (c < 160) e = 3'b110;
            else if (c == 160) e = 3'b111;
            else e = 3'b100;
            vectors++;
            if ({tx, busy, done} !== e) begin
                miscompares++; $display("FAIL basic_cycle%0d tx/busy/done got %b want %b", c, {tx, busy, done}, e);
            end
        end
        vectors++;
        if (rx_q.size() == 0) begin
            miscompares++; $display("FAIL basic_frame no frame decoded, want %h", v);
        end else begin
            r = rx_q.pop_front(); v = exp_q.pop_front();
            if (r.data !== v || r.err || r.cyc != 160) begin
                miscompares++;
                $display("FAIL basic_frame got data %h err %0d cyc %0d want %h 0 160", r.data, r.err, r.cyc, v);
            end
        end
    endtask

    task automatic test_mod53();
        logic [7:0] e;
        frame_t     r;
        int         sd0 = stray_done;
        tick_mode = 1;
        repeat (3) @(posedge clk);
        #1 din = 8'h00; start = 1'b1; exp_q.push_back(8'h00);
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 9000 && rx_q.size() == 0; i++) @(negedge clk);
        vectors++;
        if (rx_q.size() == 0) begin
            miscompares++; $display("FAIL mod53_timeout no frame after 9000 cycles, want 1 frame");
        end else begin
            r = rx_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e || r.err) begin
                miscompares++; $display("FAIL mod53_frame got %h err %0d want %h err 0", r.data, r.err, e);
            end
            vectors++;
            if (r.cyc < 159 * 53 + 1 || r.cyc > 160 * 53) begin
                miscompares++; $display("FAIL mod53_len got %0d cycles want %0d..%0d", r.cyc, 159 * 53 + 1, 160 * 53);
            end
        end
        repeat (100) @(negedge clk);
        vectors++;
        if (stray_done != sd0) begin
            miscompares++; $display("FAIL mod53_done_count got %0d extra pulses want 0", stray_done - sd0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[3] = '{8'h3C, 8'hC3, 8'h01};
        logic [7:0] e;
        frame_t     r;
        tick_mode = 0;
        repeat (2) @(posedge clk);
        #1 din = vals[0]; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(vals[k]);
            repeat (30) @(negedge clk);
            din = ~vals[k];
            for (int i = 0; i < 400 && done !== 1'b1; i++) @(negedge clk);
            vectors++;
            if (done !== 1'b1) begin
                miscompares++; $display("FAIL b2b_done_timeout frame %0d got no done want done", k);
            end
            @(posedge clk);
            #1 if (k < 2) din = vals[k + 1]; else start = 1'b0;
            @(negedge clk);
            vectors++;
            if ({tx, busy} !== 2'b10) begin
                miscompares++; $display("FAIL b2b_idle_gap frame %0d tx/busy got %b want 10", k, {tx, busy});
            end
            if (k < 2) begin
                @(negedge clk);
                vectors++;
                if ({tx, busy} !== 2'b01) begin
                    miscompares++; $display("FAIL b2b_restart frame %0d tx/busy got %b want 01", k + 1, {tx, busy});
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++; $display("FAIL b2b_data[%0d] no frame want %h", k, vals[k]);
            end else begin
                r = rx_q.pop_front(); e = exp_q.pop_front();
                if (r.data !== e || r.err) begin
                    miscompares++; $display("FAIL b2b_data[%0d] got %h err %0d want %h", k, r.data, r.err, e);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] e;
        frame_t     r;
        int         sd0;
        tick_mode = 0;
        repeat (2) @(posedge clk);
        #1 din = 8'hF0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (16 + 16 * 3 + 8) @(posedge clk);
        #1;
        vectors++;
        if ({tx, busy} !== 2'b01) begin
            miscompares++; $display("FAIL pre_reset_bit3 tx/busy got %b want 01", {tx, busy});
        end
        sd0 = stray_done;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({tx, busy, done} !== 3'b100) begin
            miscompares++; $display("FAIL async_reset tx/busy/done got %b want 100", {tx, busy, done});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; din = 8'h96; start = 1'b1; exp_q.push_back(8'h96);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({tx, busy} !== 2'b01) begin
            miscompares++; $display("FAIL first_edge_accept tx/busy got %b want 01", {tx, busy});
        end
        for (int i = 0; i < 400 && rx_q.size() == 0; i++) @(negedge clk);
        vectors++;
        if (rx_q.size() == 0) begin
            miscompares++; $display("FAIL post_reset_frame no frame want 96");
        end else begin
            r = rx_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e || r.err) begin
                miscompares++; $display("FAIL post_reset_frame got %h err %0d want %h", r.data, r.err, e);
            end
        end
        vectors++;
        if (stray_done != sd0) begin
            miscompares++; $display("FAIL abort_no_done got %0d stray pulses want 0", stray_done - sd0);
        end
    endtask

    task automatic test_params();
        logic [D7-1:0] vals[2] = '{7'h7F, 7'h29};
        logic [2:0]    e;
        tick_mode = 0;
        for (int k = 0; k < 2; k++) begin
            repeat (2) @(posedge clk);
            #1 din7 = vals[k]; start7 = 1'b1;
            @(posedge clk); #1 start7 = 1'b0; din7 = '0;
            for (int c = 1; c <= FL7 + 1; c++) begin
                @(negedge clk);
                if (c <= 16) e = 3'b010;
                else if (c <= 16 * (1 + D7)) e = {vals[k][(c - 17) / 16], 2'b10};
                else if (c < FL7) e = 3'b110;
                else if (c == FL7) e = 3'b111;
                else e = 3'b100;
                vectors++;
                if ({tx7, busy7, done7} !== e) begin
                    miscompares++;
                    $display("FAIL d7sb32_%h_cycle%0d tx/busy/done got %b want %b", vals[k], c, {tx7, busy7, done7}, e);
                end
            end
        end
    endtask

    task automatic test_irregular();
        logic [7:0] vals[2] = '{8'h5A, 8'h81};
        logic [7:0] e;
        frame_t     r;
        int         c0;
        tick_mode = 2;
        repeat (3) @(posedge clk);
        c0 = chg_err;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 din = vals[k]; start = 1'b1; exp_q.push_back(vals[k]);
            @(posedge clk); #1 start = 1'b0;
            for (int i = 0; i < 1500 && rx_q.size() == 0; i++) @(negedge clk);
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++; $display("FAIL irregular_timeout frame %0d no frame want %h", k, vals[k]);
            end else begin
                r = rx_q.pop_front(); e = exp_q.pop_front();
                if (r.data !== e || r.err) begin
                    miscompares++; $display("FAIL irregular_frame[%0d] got %h err %0d want %h err 0", k, r.data, r.err, e);
                end
            end
        end
        vectors++;
        if (chg_err != c0) begin
            miscompares++; $display("FAIL irregular_tx_change got %0d untimed changes want 0", chg_err - c0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mod53();
        test_back_to_back();
        test_reset_midframe();
        test_params();
        test_irregular();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
